// File: rtl/dmem_responder.sv
// dmem_responder: memory-side end of the MEM-stage data request interface.
// One word request at a time, LATENCY busy cycles after acceptance, one-cycle
// RVALID pulse for loads. Optional feature macro: DMEM_MISALIGN_CHK_EN rejects
// requests with ADDR[1:0]!=0 and pulses ERR; without it ERR is tied low and
// the low address bits are ignored.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        CLK,
  input  logic        RST_n,
  input  logic        MEM_EN,
  input  logic        MEM_WR,
  input  logic [31:0] ADDR,
  input  logic [31:0] WDATA,
  output logic        READY,
  output logic        RVALID,
  output logic [31:0] RDATA,
  output logic        ERR
);

  localparam int unsigned AW   = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LAT4 = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic          pend_rd;
  logic [31:0]   data_q;
  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic          accept;
  logic          misalign;
  logic          wr_go;
  logic          unused_addr;

  assign idx    = ADDR[AW+1:2];
  assign accept = MEM_EN & READY;

`ifdef DMEM_MISALIGN_CHK_EN
  assign misalign = (ADDR[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign wr_go       = RST_n & accept & MEM_WR & ~misalign;
  // Upper address bits alias; low bits only matter with the misalign check.
  assign unused_addr = ^{ADDR[31:AW+2], ADDR[1:0]};

  // Word array: stores commit on the accepting edge; contents survive reset.
  always_ff @(posedge CLK) begin
    if (wr_go) begin
      mem[idx] <= WDATA;
    end
  end

  // Request FSM with registered READY/RVALID/RDATA/ERR.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state   <= IDLE;
      READY   <= 1'b1;
      RVALID  <= 1'b0;
      RDATA   <= '0;
      ERR     <= 1'b0;
      cnt     <= '0;
      pend_rd <= 1'b0;
      data_q  <= '0;
    end else begin
      RVALID <= 1'b0;
      ERR    <= 1'b0;
      case (state)
        BUSY: begin
          if (cnt == 4'd1) begin
            cnt   <= '0;
            READY <= 1'b1;
            if (pend_rd) begin
              state  <= RESP;
              RVALID <= 1'b1;
              RDATA  <= data_q;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          // IDLE and RESP both accept; RESP lasts one cycle unless re-entered.
          state <= IDLE;
          READY <= 1'b1;
          if (accept) begin
            if (misalign) begin
              ERR <= 1'b1;
            end else begin
              pend_rd <= ~MEM_WR;
              if (!MEM_WR) begin
                data_q <= mem[idx];
              end
              if (LATENCY == 0) begin
                if (!MEM_WR) begin
                  state  <= RESP;
                  RVALID <= 1'b1;
                  RDATA  <= mem[idx];
                end
              end else begin
                state <= BUSY;
                READY <= 1'b0;
                cnt   <= LAT4;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: three responders (LATENCY 0, 2, 3) sharing clock and
// reset; table vectors, hand sequences and a randomized transaction model.
`timescale 1ns/1ps
module tb_dmem_responder;

  logic            clk;
  logic            rst_n;
  logic [2:0]      en, wr, ready, rvalid, err;
  logic [2:0][31:0] addr, wdata, rdata;

  int checks   = 0;
  int failures = 0;
  int lat [3]  = '{0, 2, 3};

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) u_lat0 (
    .CLK(clk), .RST_n(rst_n), .MEM_EN(en[0]), .MEM_WR(wr[0]), .ADDR(addr[0]),
    .WDATA(wdata[0]), .READY(ready[0]), .RVALID(rvalid[0]), .RDATA(rdata[0]), .ERR(err[0]));
  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_lat2 (
    .CLK(clk), .RST_n(rst_n), .MEM_EN(en[1]), .MEM_WR(wr[1]), .ADDR(addr[1]),
    .WDATA(wdata[1]), .READY(ready[1]), .RVALID(rvalid[1]), .RDATA(rdata[1]), .ERR(err[1]));
  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(3)) u_lat3 (
    .CLK(clk), .RST_n(rst_n), .MEM_EN(en[2]), .MEM_WR(wr[2]), .ADDR(addr[2]),
    .WDATA(wdata[2]), .READY(ready[2]), .RVALID(rvalid[2]), .RDATA(rdata[2]), .ERR(err[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          dev;
    logic        en;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rdy;
    logic        rv;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl [27];

  // Transaction-level reference model state (random phase).
  int          cyc;
  int          busy_end [3];
  int          resp_at  [3];
  int          pre      [3];
  logic [31:0] rval     [3];
  logic [31:0] rdm      [3];
  logic [31:0] mm       [3][16];
  bit          acc      [3];
  bit          mready   [3];

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dev%0d actual=%h required=%h", name, d, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input int d, input logic rdy, input logic rv,
                           input logic [31:0] rd, input logic e);
    chk({tag, "_ready"},  d, ready[d],  rdy);
    chk({tag, "_rvalid"}, d, rvalid[d], rv);
    chk({tag, "_rdata"},  d, rdata[d],  rd);
    chk({tag, "_err"},    d, err[d],    e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request, hold it until an edge sees READY=1, then drop it.
  task automatic request(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd);
    bit done;
    done = 1'b0;
    en[d] = 1'b1; wr[d] = w; addr[d] = a; wdata[d] = wd;
    for (int i = 0; i < 40; i++) begin
      done = ready[d];
      tick();
      if (done) break;
    end
    en[d] = 1'b0;
    chk("request_accept", d, 32'(done), 32'd1);
  endtask

  task automatic wait_ready(input int d);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ready[d]) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    chk("ready_return", d, 32'(got), 32'd1);
  endtask

  task automatic wait_resp(input int d, output logic [31:0] data);
    bit got;
    got  = 1'b0;
    data = '0;
    for (int i = 0; i < 40; i++) begin
      if (rvalid[d]) begin
        got  = 1'b1;
        data = rdata[d];
        break;
      end
      tick();
    end
    chk("resp_seen", d, 32'(got), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] got_data;
    logic [31:0] tmp;
    int          rv_count;
    int unsigned widx;
    bit          exp_rdy;
    bit          exp_rv;

    tbl[0]  = '{0, 1'b1, 1'b1, 32'h0,    32'h11111111, 1'b1, 1'b0, 32'h0};
    tbl[1]  = '{0, 1'b1, 1'b1, 32'h4,    32'h22222222, 1'b1, 1'b0, 32'h0};
    tbl[2]  = '{0, 1'b1, 1'b0, 32'h0,    32'h0,        1'b1, 1'b1, 32'h11111111};
    tbl[3]  = '{0, 1'b1, 1'b0, 32'h4,    32'h0,        1'b1, 1'b1, 32'h22222222};
    tbl[4]  = '{0, 1'b0, 1'b0, 32'h0,    32'h0,        1'b1, 1'b0, 32'h22222222};
    tbl[5]  = '{1, 1'b1, 1'b1, 32'h10,   32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
    tbl[6]  = '{1, 1'b1, 1'b0, 32'h10,   32'h0,        1'b0, 1'b0, 32'h0};
    tbl[7]  = '{1, 1'b1, 1'b0, 32'h10,   32'h0,        1'b1, 1'b0, 32'h0};
    tbl[8]  = '{1, 1'b1, 1'b0, 32'h10,   32'h0,        1'b0, 1'b0, 32'h0};
    tbl[9]  = '{1, 1'b0, 1'b0, 32'h0,    32'h0,        1'b0, 1'b0, 32'h0};
    tbl[10] = '{1, 1'b0, 1'b0, 32'h0,    32'h0,        1'b1, 1'b1, 32'hDEADBEEF};
    tbl[11] = '{1, 1'b0, 1'b0, 32'h0,    32'h0,        1'b1, 1'b0, 32'hDEADBEEF};
    tbl[12] = '{1, 1'b1, 1'b1, 32'h100,  32'hAAAA0001, 1'b0, 1'b0, 32'hDEADBEEF};
    tbl[13] = '{1, 1'b1, 1'b1, 32'h8,    32'h0BAD0008, 1'b0, 1'b0, 32'hDEADBEEF};
    tbl[14] = '{1, 1'b1, 1'b1, 32'h8,    32'h0BAD0008, 1'b1, 1'b0, 32'hDEADBEEF};
    tbl[15] = '{1, 1'b1, 1'b1, 32'h8,    32'h0BAD0008, 1'b0, 1'b0, 32'hDEADBEEF};
    tbl[16] = '{1, 1'b0, 1'b0, 32'h0,    32'h0,        1'b0, 1'b0, 32'hDEADBEEF};
    tbl[17] = '{1, 1'b0, 1'b0, 32'h0,    32'h0,        1'b1, 1'b0, 32'hDEADBEEF};
    tbl[18] = '{1, 1'b1, 1'b0, 32'h8,    32'h0,        1'b0, 1'b0, 32'hDEADBEEF};
    tbl[19] = '{1, 1'b0, 1'b0, 32'h0,    32'h0,        1'b0, 1'b0, 32'hDEADBEEF};
    tbl[20] = '{1, 1'b0, 1'b0, 32'h0,    32'h0,        1'b1, 1'b1, 32'h0BAD0008};
    tbl[21] = '{1, 1'b1, 1'b1, 32'h1000, 32'h5A5A1000, 1'b0, 1'b0, 32'h0BAD0008};
    tbl[22] = '{1, 1'b0, 1'b0, 32'h0,    32'h0,        1'b0, 1'b0, 32'h0BAD0008};
    tbl[23] = '{1, 1'b0, 1'b0, 32'h0,    32'h0,        1'b1, 1'b0, 32'h0BAD0008};
    tbl[24] = '{1, 1'b1, 1'b0, 32'h0,    32'h0,        1'b0, 1'b0, 32'h0BAD0008};
    tbl[25] = '{1, 1'b0, 1'b0, 32'h0,    32'h0,        1'b0, 1'b0, 32'h0BAD0008};
    tbl[26] = '{1, 1'b0, 1'b0, 32'h0,    32'h0,        1'b1, 1'b1, 32'h5A5A1000};

    // Reset held with random request traffic.
    rst_n = 1'b0; en = '0; wr = '0; addr = '0; wdata = '0;
    for (int c = 0; c < 5; c++) begin
      en = 3'($urandom); wr = 3'($urandom);
      for (int d = 0; d < 3; d++) begin
        addr[d] = $urandom; wdata[d] = $urandom;
      end
      tick();
      for (int d = 0; d < 3; d++) check_out("reset", d, 1'b1, 1'b0, 32'h0, 1'b0);
    end
    en = '0;
    rst_n = 1'b1;
    tick();
    for (int d = 0; d < 3; d++) check_out("released", d, 1'b1, 1'b0, 32'h0, 1'b0);

    // Table vectors: inputs before the edge, outputs checked after it.
    for (int i = 0; i < 27; i++) begin
      en = '0; wr = '0;
      en[tbl[i].dev]    = tbl[i].en;
      wr[tbl[i].dev]    = tbl[i].wr;
      addr[tbl[i].dev]  = tbl[i].addr;
      wdata[tbl[i].dev] = tbl[i].wdata;
      tick();
      check_out($sformatf("vec%0d", i), tbl[i].dev, tbl[i].rdy, tbl[i].rv, tbl[i].rd, 1'b0);
    end
    en = '0;

    // Misaligned store to 0x6 followed by a read of word 0x4 (LATENCY=2).
    request(1, 1'b1, 32'h4, 32'h01D00004);
    wait_ready(1);
    request(1, 1'b1, 32'h6, 32'h0E600006);
`ifdef DMEM_MISALIGN_CHK_EN
    chk("misalign_err", 1, 32'(err[1]), 32'd1);
    chk("misalign_ready", 1, 32'(ready[1]), 32'd1);
`else
    chk("misalign_err", 1, 32'(err[1]), 32'd0);
    chk("misalign_ready", 1, 32'(ready[1]), 32'd0);
`endif
    request(1, 1'b0, 32'h4, 32'h0);
    chk("after_err", 1, 32'(err[1]), 32'd0);
    wait_resp(1, got_data);
`ifdef DMEM_MISALIGN_CHK_EN
    chk("misalign_data", 1, got_data, 32'h01D00004);
`else
    chk("misalign_data", 1, got_data, 32'h0E600006);
`endif

    // Reset in cycle 1 of a read (LATENCY=3): the read is discarded.
    wait_ready(2);
    request(2, 1'b1, 32'h20, 32'hC0FFEE20);
    wait_ready(2);
    request(2, 1'b0, 32'h20, 32'h0);
    chk("rd_cycle1_ready", 2, 32'(ready[2]), 32'd0);
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) check_out("async_rst", d, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    rv_count = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rvalid[2]) rv_count++;
    end
    chk("no_stale_rvalid", 2, 32'(rv_count), 32'd0);
    request(2, 1'b0, 32'h20, 32'h0);
    wait_resp(2, got_data);
    chk("post_rst_read", 2, got_data, 32'hC0FFEE20);

    // Randomized traffic against the transaction model.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    cyc = 0;
    for (int d = 0; d < 3; d++) begin
      busy_end[d] = -10; resp_at[d] = -10; pre[d] = 0;
      rval[d] = '0; rdm[d] = '0; acc[d] = 1'b0; mready[d] = 1'b1;
    end
    en = '0;
    for (int it = 0; it < 600; it++) begin
      for (int d = 0; d < 3; d++) begin
        if (!en[d] || acc[d]) begin
          tmp = $urandom;
          if (pre[d] < 16) begin
            widx = unsigned'(pre[d]);
            en[d] = 1'b1; wr[d] = 1'b1;
            pre[d]++;
          end else begin
            widx = $urandom_range(0, 15);
            en[d] = ($urandom_range(0, 3) != 0);
            wr[d] = 1'($urandom_range(0, 1));
          end
          addr[d]  = {tmp[31:12], 6'b0, widx[3:0], 2'b00};
          wdata[d] = $urandom;
        end
        acc[d] = 1'b0;
      end
      @(posedge clk);
      cyc++;
      for (int d = 0; d < 3; d++) begin
        if (en[d] && mready[d]) begin
          acc[d] = 1'b1;
          widx = 32'(addr[d][5:2]);
          if (wr[d]) begin
            mm[d][widx] = wdata[d];
          end else begin
            rval[d]    = mm[d][widx];
            resp_at[d] = cyc + lat[d];
          end
          busy_end[d] = cyc + lat[d] - 1;
        end
      end
      #1;
      for (int d = 0; d < 3; d++) begin
        exp_rdy = (cyc > busy_end[d]);
        exp_rv  = (cyc == resp_at[d]);
        if (exp_rv) rdm[d] = rval[d];
        check_out("rand", d, exp_rdy, exp_rv, rdm[d], 1'b0);
        mready[d] = exp_rdy;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
